hamming_rr_corrector: RTL and testbench

HAMMING_RR_CORRECTOR -- requirements
Module: hamming_rr_corrector

---
 rtl/hamming_pkg.sv | 34 +++
 rtl/hamming_syndrome_fix.sv | 37 +++
 rtl/hamming_rr_corrector.sv | 130 +++++++++++++
 tb/tb_hamming_rr_corrector.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_pkg
//  Description : Shared types and constants for the Hamming(7,4) round-robin
//                corrector: FSM state encoding, codeword/syndrome widths and
//                the codeword positions that carry data bits.
//  Revision    : 1.0 - initial release
// ============================================================================
package hamming_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int c_SYN_W = 3;
    localparam int c_CW_W  = 7;

    // Data bit k of the payload lives at codeword position c_DATA_POS[k];
    // payload is {O7,O6,O5,O3}.
    localparam logic [3:0][2:0] c_DATA_POS = {3'd7, 3'd6, 3'd5, 3'd3};

    function automatic logic [3:0] extract_data(input logic [c_CW_W:1] cw);
        logic [3:0] d;
        d = '0;
        for (int k = 0; k < 4; k++) begin
            d[k] = cw[c_DATA_POS[k]];
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hamming_syndrome_fix.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_syndrome_fix
//  Description : Combinational Hamming(7,4) syndrome computation and
//                single-bit correction. The syndrome is always reported;
//                correction and the error flag only apply when EN is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_syndrome_fix
    import hamming_pkg::*;
(
    input  logic [c_CW_W:1]    D,
    input  logic               EN,
    output logic [c_CW_W:1]    O,
    output logic [c_SYN_W-1:0] syn,
    output logic               Error
);

    logic [c_CW_W:1] w_flip_mask;

    assign syn = {D[4] ^ D[5] ^ D[6] ^ D[7],
                  D[2] ^ D[3] ^ D[6] ^ D[7],
                  D[1] ^ D[3] ^ D[5] ^ D[7]};

    // One-hot mask selecting the position named by the syndrome (none for s=0)
    always_comb begin
        w_flip_mask = '0;
        for (int i = 1; i <= c_CW_W; i++) begin
            w_flip_mask[i] = EN && (syn == i[c_SYN_W-1:0]);
        end
    end

    assign O     = D ^ w_flip_mask;
    assign Error = EN && (syn != '0);

endmodule
`default_nettype wire

// File: rtl/hamming_rr_corrector.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_rr_corrector
//  Description : Two-requester round-robin front end for a Hamming(7,4)
//                corrector. A word is accepted in IDLE, checked in CHECK
//                (results registered) and held in HOLD until the consumer
//                takes it. Counts corrected words in a saturating counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module hamming_rr_corrector
    import hamming_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                EN,
    input  logic                req0_valid,
    input  logic [7:1]          req0_D,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [7:1]          req1_D,
    output logic                req1_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:1]          out_O,
    output logic [3:0]          out_data,
    output logic [2:0]          out_syn,
    output logic                out_Error,
    output logic                out_src,
    output logic [CNT_W-1:0]    err_cnt,
    input  logic                cnt_clr
);

    state_t             r_state;
    state_t             w_state_next;
    logic               r_rr_ptr;
    logic [c_CW_W:1]    r_cw;
    logic               r_src;
    logic               w_grant0;
    logic               w_grant1;
    logic [c_CW_W:1]    w_fix_O;
    logic [c_SYN_W-1:0] w_fix_syn;
    logic               w_fix_err;

    hamming_syndrome_fix u_fix (
        .D     (r_cw),
        .EN    (EN),
        .O     (w_fix_O),
        .syn   (w_fix_syn),
        .Error (w_fix_err)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state: a grant in IDLE is also an accept, since ready = grant
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_grant0 || w_grant1) w_state_next = CHECK;
            CHECK:   w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs: round-robin grant in IDLE, favoured requester first,
    // the other one taken without a bubble when the favoured one is idle
    always_comb begin
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (r_state == IDLE) begin
            if (!r_rr_ptr) begin
                w_grant0 = req0_valid;
                w_grant1 = req1_valid && !req0_valid;
            end else begin
                w_grant1 = req1_valid;
                w_grant0 = req0_valid && !req1_valid;
            end
        end
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        out_valid  = (r_state == HOLD);
    end

    // Capture accepted word, source and advance pointer to the other requester
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
            r_cw     <= '0;
            r_src    <= 1'b0;
        end else if (w_grant0 || w_grant1) begin
            r_cw     <= w_grant1 ? req1_D : req0_D;
            r_src    <= w_grant1;
            r_rr_ptr <= w_grant0;
        end
    end

    // Register results during CHECK; they stay frozen through HOLD
    always_ff @(posedge clk) begin
        if (rst) begin
            out_O     <= '0;
            out_data  <= '0;
            out_syn   <= '0;
            out_Error <= 1'b0;
            out_src   <= 1'b0;
        end else if (r_state == CHECK) begin
            out_O     <= w_fix_O;
            out_data  <= extract_data(w_fix_O);
            out_syn   <= w_fix_syn;
            out_Error <= w_fix_err;
            out_src   <= r_src;
        end
    end

    // Saturating corrected-word counter; clear beats a coincident increment
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            err_cnt <= '0;
        end else if ((r_state == CHECK) && w_fix_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hamming_rr_corrector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hamming_rr_corrector
//  Description : Self-checking bench for hamming_rr_corrector. A default
//                (CNT_W=8) and a narrow (CNT_W=2) instance share stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hamming_rr_corrector;

    logic       clk = 1'b0;
    logic       rst, EN, req0_valid, req1_valid, out_ready, cnt_clr;
    logic [7:1] req0_D, req1_D;

    logic       a_req0_ready, a_req1_ready, a_out_valid, a_out_Error, a_out_src;
    logic [7:1] a_out_O;
    logic [3:0] a_out_data;
    logic [2:0] a_out_syn;
    logic [7:0] a_err_cnt;

    logic       b_req0_ready, b_req1_ready, b_out_valid, b_out_Error, b_out_src;
    logic [7:1] b_out_O;
    logic [3:0] b_out_data;
    logic [2:0] b_out_syn;
    logic [1:0] b_err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hamming_rr_corrector u_dut_a (
        .clk(clk), .rst(rst), .EN(EN),
        .req0_valid(req0_valid), .req0_D(req0_D), .req0_ready(a_req0_ready),
        .req1_valid(req1_valid), .req1_D(req1_D), .req1_ready(a_req1_ready),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_O(a_out_O),
        .out_data(a_out_data), .out_syn(a_out_syn), .out_Error(a_out_Error),
        .out_src(a_out_src), .err_cnt(a_err_cnt), .cnt_clr(cnt_clr)
    );

    hamming_rr_corrector #(.CNT_W(2)) u_dut_b (
        .clk(clk), .rst(rst), .EN(EN),
        .req0_valid(req0_valid), .req0_D(req0_D), .req0_ready(b_req0_ready),
        .req1_valid(req1_valid), .req1_D(req1_D), .req1_ready(b_req1_ready),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_O(b_out_O),
        .out_data(b_out_data), .out_syn(b_out_syn), .out_Error(b_out_Error),
        .out_src(b_out_src), .err_cnt(b_err_cnt), .cnt_clr(cnt_clr)
    );

    typedef struct {
        logic       src;
        logic       en;
        logic [7:1] d;
        logic [7:1] o;
        logic [3:0] data;
        logic [2:0] syn;
        logic       err;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; EN = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_D = '0; req1_D = '0; out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge with request inputs already driven
    task automatic wait_grant(input logic sel, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        for (int t = 0; t < 20 && !ok; t++) begin
            #1;
            if ((sel ? a_req1_ready : a_req0_ready) === 1'b1) ok = 1'b1;
            else begin
                waited++;
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout: requester %0d ready stayed low, expected high within 20 cycles", sel);
        end
    endtask

    task automatic check_result(input vec_t v, input string tag);
        chk({tag, "_valid_a"}, 32'(a_out_valid), 32'd1);
        chk({tag, "_O_a"},     32'(a_out_O),     32'(v.o));
        chk({tag, "_data_a"},  32'(a_out_data),  32'(v.data));
        chk({tag, "_syn_a"},   32'(a_out_syn),   32'(v.syn));
        chk({tag, "_err_a"},   32'(a_out_Error), 32'(v.err));
        chk({tag, "_src_a"},   32'(a_out_src),   32'(v.src));
        chk({tag, "_cnt_a"},   32'(a_err_cnt),   32'(v.cnt_a));
        chk({tag, "_valid_b"}, 32'(b_out_valid), 32'd1);
        chk({tag, "_O_b"},     32'(b_out_O),     32'(v.o));
        chk({tag, "_data_b"},  32'(b_out_data),  32'(v.data));
        chk({tag, "_syn_b"},   32'(b_out_syn),   32'(v.syn));
        chk({tag, "_err_b"},   32'(b_out_Error), 32'(v.err));
        chk({tag, "_src_b"},   32'(b_out_src),   32'(v.src));
        chk({tag, "_cnt_b"},   32'(b_err_cnt),   32'(v.cnt_b));
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int waited;
        @(negedge clk);
        EN = v.en;
        req0_valid = !v.src;
        req1_valid = v.src;
        if (v.src) req1_D = v.d;
        else       req0_D = v.d;
        wait_grant(v.src, ok, waited);
        if (!ok) begin
            req0_valid = 1'b0; req1_valid = 1'b0;
            return;
        end
        chk("grant_bubble", 32'(waited), 32'd0);
        chk("readys_a", 32'({a_req1_ready, a_req0_ready}), v.src ? 32'd2 : 32'd1);
        chk("readys_b", 32'({b_req1_ready, b_req0_ready}), v.src ? 32'd2 : 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("valid_in_check", 32'(a_out_valid), 32'd0);
        @(negedge clk);
        check_result(v, "hold");
        EN = ~EN;
        @(negedge clk);
        check_result(v, "hold_en_flip");
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_after_handshake", 32'(a_out_valid), 32'd0);
    endtask

    initial begin
        bit         ok;
        int         waited;
        logic       exp_src;
        logic [7:1] exp_o;

        //            src   en    d      o      data     syn     err  cnt_a cnt_b
        vecs[0] = '{1'b0, 1'b1, 7'h55, 7'h55, 4'b1011, 3'b000, 1'b0, 8'd0, 2'd0};
        vecs[1] = '{1'b1, 1'b1, 7'h75, 7'h55, 4'b1011, 3'b110, 1'b1, 8'd1, 2'd1};
        vecs[2] = '{1'b0, 1'b0, 7'h75, 7'h75, 4'b1111, 3'b110, 1'b0, 8'd1, 2'd1};
        vecs[3] = '{1'b1, 1'b1, 7'h54, 7'h55, 4'b1011, 3'b001, 1'b1, 8'd2, 2'd2};
        vecs[4] = '{1'b0, 1'b1, 7'h40, 7'h00, 4'b0000, 3'b111, 1'b1, 8'd3, 2'd3};
        vecs[5] = '{1'b1, 1'b1, 7'h77, 7'h7F, 4'b1111, 3'b100, 1'b1, 8'd4, 2'd3};
        vecs[6] = '{1'b0, 1'b1, 7'h03, 7'h07, 4'b0001, 3'b011, 1'b1, 8'd5, 2'd3};
        vecs[7] = '{1'b1, 1'b1, 7'h7F, 7'h7F, 4'b1111, 3'b000, 1'b0, 8'd5, 2'd3};
        vecs[8] = '{1'b1, 1'b0, 7'h00, 7'h00, 4'b0000, 3'b000, 1'b0, 8'd5, 2'd3};

        // Reset state
        do_reset();
        #1;
        chk("rst_valid",  32'(a_out_valid), 32'd0);
        chk("rst_readys", 32'({a_req1_ready, a_req0_ready}), 32'd0);
        chk("rst_O",      32'(a_out_O),     32'd0);
        chk("rst_data",   32'(a_out_data),  32'd0);
        chk("rst_syn",    32'(a_out_syn),   32'd0);
        chk("rst_err",    32'(a_out_Error), 32'd0);
        chk("rst_src",    32'(a_out_src),   32'd0);
        chk("rst_cnt_a",  32'(a_err_cnt),   32'd0);
        chk("rst_cnt_b",  32'(b_err_cnt),   32'd0);

        // Directed vectors
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Arbitration with both requesters always valid and held backpressure
        do_reset();
        EN = 1'b1;
        req0_D = 7'h54;
        req1_D = 7'h03;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int g = 0; g < 4; g++) begin
            exp_src = (g % 2) == 1;
            exp_o   = exp_src ? 7'h07 : 7'h55;
            #1;
            chk("arb_grant", 32'({a_req1_ready, a_req0_ready}), exp_src ? 32'd2 : 32'd1);
            @(posedge clk);
            @(negedge clk);
            chk("arb_ready_check", 32'({a_req1_ready, a_req0_ready}), 32'd0);
            for (int h = 0; h < 5; h++) begin
                @(negedge clk);
                chk("arb_hold_valid", 32'(a_out_valid), 32'd1);
                chk("arb_hold_ready", 32'({a_req1_ready, a_req0_ready}), 32'd0);
                chk("arb_hold_O",     32'(a_out_O),     32'(exp_o));
                chk("arb_hold_src",   32'(a_out_src),   32'(exp_src));
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        chk("arb_cnt_a", 32'(a_err_cnt), 32'd4);
        chk("arb_cnt_b", 32'(b_err_cnt), 32'd3);

        // Clear coinciding with an increment
        @(negedge clk);
        req0_D = 7'h54;
        req0_valid = 1'b1;
        wait_grant(1'b0, ok, waited);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0;
            cnt_clr = 1'b1;
            @(negedge clk);
            cnt_clr = 1'b0;
            chk("clr_cnt_a", 32'(a_err_cnt),   32'd0);
            chk("clr_cnt_b", 32'(b_err_cnt),   32'd0);
            chk("clr_err",   32'(a_out_Error), 32'd1);
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        req0_valid = 1'b0;

        // Reset while holding a result from requester 0 (pointer now at 1)
        @(negedge clk);
        req0_D = 7'h75;
        req0_valid = 1'b1;
        wait_grant(1'b0, ok, waited);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            req0_valid = 1'b0;
            @(negedge clk);
            chk("rh_valid_before", 32'(a_out_valid), 32'd1);
            chk("rh_cnt_before",   32'(a_err_cnt),   32'd1);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rh_valid", 32'(a_out_valid), 32'd0);
            chk("rh_O",     32'(a_out_O),     32'd0);
            chk("rh_syn",   32'(a_out_syn),   32'd0);
            chk("rh_err",   32'(a_out_Error), 32'd0);
            chk("rh_cnt",   32'(a_err_cnt),   32'd0);
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            #1;
            chk("rh_next_grant", 32'({a_req1_ready, a_req0_ready}), 32'd1);
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        req0_valid = 1'b0;

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
